if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage ARM pipeline: PC register, PC+4 incrementer, branch redirect,
//  req/ack handshake to instruction memory, and the IF/ID output latch. Stalls on the hazard
//  unit's load enable; flushes on a taken branch from the EX-stage condition tester. Feeds decode/CU.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INST   32'h0000_0000  bubble word driven into IF/ID on reset/flush
// PORTS
//  CLK         in   1   clock; all state updates on posedge
//  CLR         in   1   synchronous active-high reset
//  LE          in   1   hazard-unit load enable: 1 = IF/ID may advance, 0 = stall
//  BR_TAKEN    in   1   taken B/BL resolved in EX; redirect and flush
//  BR_TARGET   in   32  branch target address; bits [1:0] ignored (forced 0)
//  imem_req    out  1   fetch request to instruction memory
//  imem_addr   out  32  word-aligned fetch address; stable while imem_req=1 and no ack
//  imem_ack    in   1   memory returns imem_rdata this cycle (0..N wait states)
//  imem_rdata  in   32  instruction word, valid only when imem_ack=1
//  PC          out  32  current PC (next address to fetch)
//  IFID_inst   out  32  instruction latched for ID
//  IFID_pc4    out  32  fetch address + 4 of IFID_inst
//  IFID_valid  out  1   IFID_inst is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (CLR=1 at posedge, highest priority): PC=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC,
//   IFID_inst=NOP_INST, IFID_pc4=0, IFID_valid=0, hold buffer cleared. First req issues the cycle after.
//  States: FETCH (request outstanding), HOLD (word held, ID stalled), DRAIN (discarding stale fetch).
//  FETCH: imem_req=1, imem_addr=issued address (registered at issue; never changes until ack).
//   ack & LE & !BR_TAKEN: IFID_inst<=rdata, IFID_pc4<=addr+4, valid<=1, PC<=PC+4, next req to PC+4.
//   ack & !LE & !BR_TAKEN: rdata->hold buffer, IFID regs unchanged, -> HOLD, imem_req=0 next cycle.
//   !ack & !BR_TAKEN: wait; if LE=1 IFID_valid<=0 / IFID_inst<=NOP_INST (bubble), else IFID holds.
//  HOLD: imem_req=0. LE=1: IFID<=buffer (valid=1), PC<=PC+4, -> FETCH. LE=0: stay.
//  BR_TAKEN (overrides LE and ack): PC<=BR_TARGET&~3; IFID_inst<=NOP_INST, valid<=0; buffer discarded.
//   From HOLD, or FETCH with ack same cycle: -> FETCH at target next cycle (rdata dropped).
//   From FETCH without ack: -> DRAIN; req/addr stay on old address until ack, data discarded, then FETCH target.
//   In DRAIN a further BR_TAKEN only replaces PC with the newer target.
//  Throughput: zero-wait memory (ack same cycle as req) gives one instruction per cycle; k wait states
//   give one per k+1 cycles. Branch penalty: flush of IF/ID plus any drain cycles.
//  Arithmetic: PC+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag). PC[1:0] always 00.
//  No combinational path from imem_rdata/imem_ack to imem_req/imem_addr; LE/BR_TAKEN affect regs only.
// TESTING
//  1 Reset then zero-wait ack, LE=1, mem[i]=0xE0000000+i -> IFID_inst 0xE0000000,+1,+2 on consecutive
//    cycles, IFID_pc4 = 4,8,12, PC = 4,8,12, IFID_valid=1 from 2nd cycle after reset.
//  2 Stall: LE=0 for 3 cycles while ack arrives -> IFID unchanged, imem_req drops, PC frozen; LE=1 ->
//    held word appears next cycle, no word lost or duplicated.
//  3 Branch with same-cycle ack: BR_TAKEN=1, BR_TARGET=0x40 -> next IFID_valid=0, next imem_addr=0x40,
//    following IFID_inst=mem[0x40], IFID_pc4=0x44.
//  4 Branch during 2-wait-state fetch at 0x10 with target 0x83 -> imem_addr holds 0x10 until ack, its
//    data never reaches IFID, then req at 0x80.
//  5 Wrap: RESET_PC=0xFFFF_FFF8, zero-wait -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//  6 CLR asserted mid-HOLD and mid-DRAIN -> all outputs to reset values next edge; refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4, branch redirect, single-outstanding fetch to instruction
// memory, hold buffer for a word fetched while ID is stalled, and the IF/ID output latch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        LE,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_inst,
  output logic [31:0] IFID_pc4,
  output logic        IFID_valid,
  output logic [1:0]  dbg_state_o
);

  // Memory handshake: imem_req and imem_addr come straight from registers. A word transfers in any
  // cycle with imem_req && imem_ack; until then imem_addr is held. imem_ack without imem_req is ignored.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic        xfer;
  logic        unused_br_lsb;

  assign pc_plus4      = pc_q + 32'd4;
  assign br_tgt        = {BR_TARGET[31:2], 2'b00};
  assign xfer          = req_q & imem_ack;
  assign unused_br_lsb = ^BR_TARGET[1:0];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    case (state_q)
      S_FETCH: begin
        if (BR_TAKEN) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          pc_d    = br_tgt;
          // With nothing in flight (or the fetch completing now) the target can be issued at once.
          if (xfer || !req_q) begin
            req_d  = 1'b1;
            addr_d = br_tgt;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (xfer) begin
          if (LE) begin
            inst_d  = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            addr_d  = pc_plus4;
            req_d   = 1'b1;
          end else begin
            buf_d   = imem_rdata;
            req_d   = 1'b0;
            state_d = S_HOLD;
          end
        end else begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
          if (LE) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (BR_TAKEN) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          pc_d    = br_tgt;
          buf_d   = NOP_INST;
          req_d   = 1'b1;
          addr_d  = br_tgt;
          state_d = S_FETCH;
        end else if (LE) begin
          inst_d  = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        // The stale fetch must complete before the redirected address can be issued.
        if (BR_TAKEN) begin
          pc_d = br_tgt;
        end
        if (xfer) begin
          req_d   = 1'b1;
          addr_d  = BR_TAKEN ? br_tgt : pc_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INST;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign PC          = pc_q;
  assign IFID_inst   = inst_q;
  assign IFID_pc4    = pc4_q;
  assign IFID_valid  = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vectors, a spec-level model compared every cycle, an in-order
// scoreboard of words consumed by ID, and literal expectations at key points.
module tb_if_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, le, br_taken;
  logic [31:0] br_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, ifid_inst, ifid_pc4;
  logic        ifid_valid;
  logic [1:0]  dbg_state_unused;

  logic        clr2, req2, ack2;
  logic [31:0] addr2, rdata2, pc2, inst2, pc4_2;
  logic        valid2;
  logic [1:0]  dbg2_unused;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  // Memory with a programmable number of wait states per request.
  int wait_cfg = 0;
  int ws_cnt = 0;
  always @(posedge clk) begin
    if (clr || !imem_req || imem_ack) ws_cnt <= 0;
    else ws_cnt <= ws_cnt + 1;
  end
  assign imem_ack   = imem_req && (ws_cnt >= wait_cfg);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  assign ack2   = req2;
  assign rdata2 = mem_word(addr2);

  if_fetch_stage dut (
    .CLK(clk), .CLR(clr), .LE(le), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PC(pc), .IFID_inst(ifid_inst), .IFID_pc4(ifid_pc4), .IFID_valid(ifid_valid),
    .dbg_state_o(dbg_state_unused)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .CLR(clr2), .LE(1'b1), .BR_TAKEN(1'b0), .BR_TARGET(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .PC(pc2), .IFID_inst(inst2), .IFID_pc4(pc4_2), .IFID_valid(valid2),
    .dbg_state_o(dbg2_unused)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the stage should show after each clock edge, from the fetch rules.
  logic        m_req, m_valid, m_holding, m_draining;
  logic [31:0] m_addr, m_pc, m_inst, m_pc4, m_buf;

  task automatic issue(input logic [31:0] a);
    m_req  = 1'b1;
    m_addr = a;
  endtask

  task automatic flush();
    m_inst  = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        got_word;
    tgt      = br_target & ~32'h3;
    got_word = imem_ack && m_req;
    if (clr) begin
      m_req = 1'b0; m_addr = 32'h0; m_pc = 32'h0; m_buf = 32'h0;
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_holding = 1'b0; m_draining = 1'b0;
    end else if (m_holding) begin
      if (br_taken) begin
        flush(); m_pc = tgt; m_holding = 1'b0; issue(tgt);
      end else if (le) begin
        m_inst = m_buf; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_holding = 1'b0; issue(m_pc);
      end
    end else if (m_draining) begin
      if (br_taken) m_pc = tgt;
      if (got_word) begin
        m_draining = 1'b0; issue(m_pc);
      end
    end else begin
      if (br_taken) begin
        flush(); m_pc = tgt;
        if (got_word || !m_req) issue(tgt);
        else m_draining = 1'b1;
      end else if (got_word) begin
        if (le) begin
          m_inst = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4; issue(m_pc);
        end else begin
          m_buf = imem_rdata; m_req = 1'b0; m_holding = 1'b1;
        end
      end else begin
        if (!m_req) issue(m_pc);
        if (le) flush();
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  bit cmp_en = 1'b0;
  bit sb_en  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) chk("m_addr", imem_addr, m_addr);
        chk("m_pc", pc, m_pc);
        chk("m_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("m_inst", ifid_inst, m_inst);
        if (m_valid) chk("m_pc4", ifid_pc4, m_pc4);
      end
      // ID consumes the IF/ID word when it is valid, loading, and not squashed by a branch.
      if (sb_en && ifid_valid && le && !br_taken) begin
        if (exp_q.size() == 0) chk("sb_extra", ifid_inst, 32'hFFFF_FFFF);
        else chk("sb_word", ifid_inst, exp_q.pop_front());
      end
      model_step();
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},   32'h0);
    chk({tag, "_addr"},  imem_addr,           32'h0);
    chk({tag, "_pc"},    pc,                  32'h0);
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, "_inst"},  ifid_inst,           32'h0);
    chk({tag, "_pc4"},   ifid_pc4,            32'h0);
  endtask

  initial begin
    clr = 1'b1; clr2 = 1'b1; le = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    for (int i = 0; i < 20; i++) exp_q.push_back(32'hE000_0000 + i);
    tick(2);
    chk_reset("rst");
    chk("rst2_pc", pc2, 32'hFFFF_FFF8);
    chk("rst2_addr", addr2, 32'hFFFF_FFF8);
    chk("rst2_req", {31'b0, req2}, 32'h0);
    cmp_en = 1'b1; sb_en = 1'b1;

    // 1: zero-wait streaming
    clr = 1'b0;
    tick(1);
    chk("t1_first_req", {31'b0, imem_req}, 32'h1);
    chk("t1_first_addr", imem_addr, 32'h0);
    chk("t1_first_valid", {31'b0, ifid_valid}, 32'h0);
    tick(1);
    chk("t1_inst0", ifid_inst, 32'hE000_0000);
    chk("t1_pc4_0", ifid_pc4, 32'h4);
    chk("t1_pc_0", pc, 32'h4);
    chk("t1_valid0", {31'b0, ifid_valid}, 32'h1);
    tick(1);
    chk("t1_inst1", ifid_inst, 32'hE000_0001);
    chk("t1_pc4_1", ifid_pc4, 32'h8);
    tick(1);
    chk("t1_inst2", ifid_inst, 32'hE000_0002);
    chk("t1_pc_2", pc, 32'hC);

    // 2: stall three cycles while the next word arrives
    le = 1'b0;
    tick(1);
    chk("t2_req_drop", {31'b0, imem_req}, 32'h0);
    chk("t2_inst_hold", ifid_inst, 32'hE000_0002);
    chk("t2_pc_frozen", pc, 32'hC);
    tick(2);
    chk("t2_inst_hold3", ifid_inst, 32'hE000_0002);
    chk("t2_pc_frozen3", pc, 32'hC);
    le = 1'b1;
    tick(1);
    chk("t2_held_word", ifid_inst, 32'hE000_0003);
    chk("t2_held_pc4", ifid_pc4, 32'h10);
    chk("t2_addr_next", imem_addr, 32'h10);
    tick(1);
    sb_en = 1'b0;

    // 3: branch with same-cycle ack
    br_taken = 1'b1; br_target = 32'h40;
    tick(1);
    br_taken = 1'b0;
    chk("t3_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_pc", pc, 32'h40);
    tick(1);
    chk("t3_inst", ifid_inst, 32'hE000_0010);
    chk("t3_pc4", ifid_pc4, 32'h44);

    // 4: branch into 0x10, then redirect to 0x83 during a 2-wait-state fetch
    br_taken = 1'b1; br_target = 32'h10;
    tick(1);
    br_taken = 1'b1; br_target = 32'h83; wait_cfg = 2;
    tick(1);
    br_taken = 1'b0;
    chk("t4_drain_addr", imem_addr, 32'h10);
    chk("t4_drain_pc", pc, 32'h80);
    chk("t4_drain_req", {31'b0, imem_req}, 32'h1);
    tick(1);
    chk("t4_drain_addr2", imem_addr, 32'h10);
    tick(1);
    chk("t4_target_addr", imem_addr, 32'h80);
    chk("t4_no_stale", ifid_inst, 32'h0);
    chk("t4_no_stale_v", {31'b0, ifid_valid}, 32'h0);
    tick(3);
    chk("t4_target_inst", ifid_inst, 32'hE000_0020);
    chk("t4_target_pc4", ifid_pc4, 32'h84);

    // 6: reset in HOLD, reset in DRAIN, branch out of HOLD
    wait_cfg = 0; le = 1'b0;
    tick(1);
    chk("t6_hold_req", {31'b0, imem_req}, 32'h0);
    chk("t6_hold_pc", pc, 32'h84);
    clr = 1'b1;
    tick(1);
    chk_reset("t6_hold_rst");
    clr = 1'b0; le = 1'b1;
    tick(2);
    chk("t6_refetch", ifid_inst, 32'hE000_0000);
    chk("t6_refetch_pc", pc, 32'h4);
    wait_cfg = 3; br_taken = 1'b1; br_target = 32'h200;
    tick(1);
    br_target = 32'h300;
    tick(1);
    chk("t6_drain_pc", pc, 32'h300);
    chk("t6_drain_addr", imem_addr, 32'h4);
    br_taken = 1'b0; clr = 1'b1;
    tick(1);
    chk_reset("t6_drain_rst");
    clr = 1'b0; wait_cfg = 0;
    tick(2);
    chk("t6_refetch2", ifid_inst, 32'hE000_0000);
    chk("t6_refetch2_v", {31'b0, ifid_valid}, 32'h1);
    le = 1'b0;
    tick(1);
    br_taken = 1'b1; br_target = 32'h100;
    tick(1);
    chk("t6_hbr_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t6_hbr_addr", imem_addr, 32'h100);
    chk("t6_hbr_req", {31'b0, imem_req}, 32'h1);
    br_taken = 1'b0; le = 1'b1;
    tick(1);
    chk("t6_hbr_inst", ifid_inst, 32'hE000_0040);
    chk("t6_hbr_pc4", ifid_pc4, 32'h104);

    // 5: PC wrap on the second instance
    clr2 = 1'b0;
    tick(1);
    chk("t5_addr0", addr2, 32'hFFFF_FFF8);
    chk("t5_req0", {31'b0, req2}, 32'h1);
    tick(1);
    chk("t5_addr1", addr2, 32'hFFFF_FFFC);
    chk("t5_inst0", inst2, 32'h1FFF_FFFE);
    chk("t5_pc4_0", pc4_2, 32'hFFFF_FFFC);
    tick(1);
    chk("t5_addr2", addr2, 32'h0);
    chk("t5_pc2", pc2, 32'h0);
    chk("t5_pc4_1", pc4_2, 32'h0);
    chk("t5_valid", {31'b0, valid2}, 32'h1);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
